// File: rtl/adc_clk_pkg.sv
// Shared definitions for the ADC sample-clock strobe generator:
// FSM state encoding, default sizing constants and small helpers.
package adc_clk_pkg;

   localparam int NUM_CH_DEF     = 2;
   localparam int DIV_W_DEF      = 8;
   localparam int SETTLE_CYC_DEF = 1024;

   // Lock-tracking FSM: wait for lock, let the PLL settle, then run strobes.
   typedef enum logic [1:0] {
      ST_WAIT_LOCK = 2'd0,
      ST_SETTLE    = 2'd1,
      ST_RUN       = 2'd2
   } state_t;

   // Event counter increment that sticks at all-ones instead of wrapping.
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/clk_strobe_ch.sv
// One strobe channel: period counter (0..div), phase compare and the
// registered single-cycle clock-enable strobe.
module clk_strobe_ch
   import adc_clk_pkg::*;
#(
   parameter int DIV_W = DIV_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic             en,
   input  logic             clear,
   input  logic [DIV_W-1:0] div,
   input  logic [DIV_W-1:0] phase,
   output logic             strobe
);

   logic [DIV_W-1:0] cnt;

   // Period counter: held at zero outside RUN, realigned whenever a new
   // configuration is captured so all channels restart from a common point.
   // The >= compare keeps the counter bounded even if div shrinks under it.
   always_ff @(posedge clk) begin
      if (rst || !run || clear) begin
         cnt <= '0;
      end else if (cnt >= div) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + DIV_W'(1);
      end
   end

   // Strobe one cycle after the counter hits phase; en already excludes the
   // last RUN cycle before a lock loss, and the reconfiguration cycle is
   // suppressed so stale settings never produce an extra pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         strobe <= 1'b0;
      end else begin
         strobe <= en && !clear && (div != '0) && (cnt == phase);
      end
   end

endmodule

// File: rtl/adc_clk_strobe_gen.sv
// ADC sample-clock strobe generator: synchronises the PLL lock flag, waits
// for a settle window, then emits per-channel phase-aligned strobes derived
// from refclk. Tracks lock losses while running.
module adc_clk_strobe_gen
   import adc_clk_pkg::*;
#(
   parameter int NUM_CH     = NUM_CH_DEF,
   parameter int DIV_W      = DIV_W_DEF,
   parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
   input  logic                    refclk,
   input  logic                    rst,
   input  logic                    pll_locked,
   input  logic [NUM_CH*DIV_W-1:0] div,
   input  logic [NUM_CH*DIV_W-1:0] phase,
   input  logic                    cfg_load,
   input  logic                    lost_clr,
   output logic [NUM_CH-1:0]       strobe,
   output logic                    ready,
   output logic                    lock_lost,
   output logic [7:0]              lost_cnt
);

   localparam int            SW          = $clog2(SETTLE_CYC);
   localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);

   logic                    lk_p0;
   logic                    lk_s;
   state_t                  state;
   logic [SW-1:0]           settle_cnt;
   logic [NUM_CH*DIV_W-1:0] div_q;
   logic [NUM_CH*DIV_W-1:0] phase_q;
   logic                    in_run;
   logic                    run_en;

   // Two-flop synchroniser for the asynchronous PLL lock indication.
   always_ff @(posedge refclk) begin
      if (rst) begin
         lk_p0 <= 1'b0;
         lk_s  <= 1'b0;
      end else begin
         lk_p0 <= pll_locked;
         lk_s  <= lk_p0;
      end
   end

   // Lock FSM with registered ready and lock-loss bookkeeping; a loss event
   // in the same cycle as lost_clr counts from the cleared value.
   always_ff @(posedge refclk) begin
      if (rst) begin
         state      <= ST_WAIT_LOCK;
         settle_cnt <= '0;
         ready      <= 1'b0;
         lock_lost  <= 1'b0;
         lost_cnt   <= 8'd0;
      end else begin
         if (lost_clr) begin
            lock_lost <= 1'b0;
            lost_cnt  <= 8'd0;
         end
         case (state)
            ST_WAIT_LOCK: begin
               if (lk_s) begin
                  state      <= ST_SETTLE;
                  settle_cnt <= '0;
               end
            end
            ST_SETTLE: begin
               if (!lk_s) begin
                  state <= ST_WAIT_LOCK;
               end else if (settle_cnt == SETTLE_LAST) begin
                  state <= ST_RUN;
                  ready <= 1'b1;
               end else begin
                  settle_cnt <= settle_cnt + SW'(1);
               end
            end
            ST_RUN: begin
               if (!lk_s) begin
                  state     <= ST_WAIT_LOCK;
                  ready     <= 1'b0;
                  lock_lost <= 1'b1;
                  lost_cnt  <= sat_inc8(lost_clr ? 8'd0 : lost_cnt);
               end
            end
            default: begin
               state <= ST_WAIT_LOCK;
               ready <= 1'b0;
            end
         endcase
      end
   end

   // Shadow copy of the channel configuration, captured on cfg_load.
   always_ff @(posedge refclk) begin
      if (rst) begin
         div_q   <= '0;
         phase_q <= '0;
      end else if (cfg_load) begin
         div_q   <= div;
         phase_q <= phase;
      end
   end

   // run holds the counters at zero outside RUN; run_en additionally drops
   // in the final RUN cycle of a lock loss so no strobe leaks past exit.
   assign in_run = (state == ST_RUN);
   assign run_en = in_run && lk_s;

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      clk_strobe_ch #(
         .DIV_W (DIV_W)
      ) u_ch (
         .clk    (refclk),
         .rst    (rst),
         .run    (in_run),
         .en     (run_en),
         .clear  (cfg_load),
         .div    (div_q[k*DIV_W +: DIV_W]),
         .phase  (phase_q[k*DIV_W +: DIV_W]),
         .strobe (strobe[k])
      );
   end

endmodule

// File: tb/tb_adc_clk_strobe_gen.sv
// Bench for adc_clk_strobe_gen: cycle-level reference model built from the
// lock/settle/period rules, directed scenarios plus randomized traffic.
module tb_adc_clk_strobe_gen;

   localparam int NUM_CH     = 2;
   localparam int DIV_W      = 8;
   localparam int SETTLE_CYC = 16;

   logic                    refclk;
   logic                    rst;
   logic                    pll_locked;
   logic [NUM_CH*DIV_W-1:0] div;
   logic [NUM_CH*DIV_W-1:0] phase;
   logic                    cfg_load;
   logic                    lost_clr;
   logic [NUM_CH-1:0]       strobe;
   logic                    ready;
   logic                    lock_lost;
   logic [7:0]              lost_cnt;

   adc_clk_strobe_gen #(
      .NUM_CH     (NUM_CH),
      .DIV_W      (DIV_W),
      .SETTLE_CYC (SETTLE_CYC)
   ) dut (
      .refclk     (refclk),
      .rst        (rst),
      .pll_locked (pll_locked),
      .div        (div),
      .phase      (phase),
      .cfg_load   (cfg_load),
      .lost_clr   (lost_clr),
      .strobe     (strobe),
      .ready      (ready),
      .lock_lost  (lock_lost),
      .lost_cnt   (lost_cnt)
   );

   initial refclk = 1'b0;
   always #5 refclk = ~refclk;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   // Reference model state: lock history as a two-edge delay line, length of
   // the current uninterrupted lock run, and the edge at which the channel
   // periods were last aligned.
   bit                lkq[$];
   int                streak;
   bit                m_run;
   bit                m_lost;
   int                m_lcnt;
   int                m_div[NUM_CH];
   int                m_ph[NUM_CH];
   int                align;
   int                tick = 0;
   logic [NUM_CH-1:0] m_stb;

   task automatic model_edge();
      bit dec;
      bit run_nx;
      tick++;
      if (rst) begin
         lkq.delete();
         lkq.push_back(1'b0);
         lkq.push_back(1'b0);
         streak = 0;
         m_run  = 1'b0;
         m_lost = 1'b0;
         m_lcnt = 0;
         m_stb  = '0;
         for (int k = 0; k < NUM_CH; k++) begin
            m_div[k] = 0;
            m_ph[k]  = 0;
         end
         align = tick;
         return;
      end
      dec = lkq.pop_front();
      lkq.push_back(pll_locked);
      streak = dec ? ((streak < 1000000) ? streak + 1 : streak) : 0;
      // One edge to leave WAIT_LOCK plus SETTLE_CYC settle edges.
      run_nx = (streak >= SETTLE_CYC + 1);
      if (lost_clr) begin
         m_lost = 1'b0;
         m_lcnt = 0;
      end
      if (m_run && !dec) begin
         m_lost = 1'b1;
         if (m_lcnt < 255) m_lcnt++;
      end
      for (int k = 0; k < NUM_CH; k++) begin
         bit hit;
         hit = 1'b0;
         if (m_run && m_div[k] != 0)
            hit = (((tick - 1 - align) % (m_div[k] + 1)) == m_ph[k]);
         m_stb[k] = m_run && run_nx && !cfg_load && hit;
      end
      if (cfg_load) begin
         for (int k = 0; k < NUM_CH; k++) begin
            m_div[k] = int'(div[k*DIV_W +: DIV_W]);
            m_ph[k]  = int'(phase[k*DIV_W +: DIV_W]);
         end
      end
      if (cfg_load || (run_nx && !m_run)) align = tick;
      m_run = run_nx;
   endtask

   task automatic step();
      @(posedge refclk);
      model_edge();
      #1;
      chk("ready", 32'(ready), 32'(m_run));
      chk("strobe", 32'(strobe), 32'(m_stb));
      chk("lock_lost", 32'(lock_lost), 32'(m_lost));
      chk("lost_cnt", 32'(lost_cnt), 32'(m_lcnt));
   endtask

   task automatic wait_ready(output int n, input int limit);
      n = 0;
      while (!ready && n < limit) begin
         step();
         n++;
      end
      if (!ready) chk("ready_timeout", 32'(ready), 32'd1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int first0, first1, prev0, prev1, cnt_s;

      rst        = 1'b1;
      pll_locked = 1'b1;
      cfg_load   = 1'b0;
      lost_clr   = 1'b0;
      div        = '0;
      phase      = '0;
      #2;
      do_reset();
      chk("rst_ready", 32'(ready), 32'd0);
      chk("rst_lost_cnt", 32'(lost_cnt), 32'd0);

      // Power-up lock latency: 2 sync + 16 settle + 1.
      wait_ready(n, 40);
      chk("settle_lat", n, 19);

      // Two channels with different periods and phases.
      div   = {8'd4, 8'd3};
      phase = {8'd2, 8'd0};
      cfg_load = 1'b1;
      step();
      cfg_load = 1'b0;
      first0 = -1; first1 = -1; prev0 = -1; prev1 = -1;
      for (int i = 1; i <= 40; i++) begin
         step();
         if (strobe[0]) begin
            if (first0 < 0) first0 = i;
            else chk("ch0_gap", i - prev0, 4);
            prev0 = i;
         end
         if (strobe[1]) begin
            if (first1 < 0) first1 = i;
            else chk("ch1_gap", i - prev1, 5);
            prev1 = i;
         end
      end
      chk("ch0_first", first0, 1);
      chk("ch1_first", first1, 3);

      // Single-cycle lock glitch at settle count 10 restarts the settle window.
      do_reset();
      n = -1;
      for (int i = 1; i <= 60; i++) begin
         pll_locked = (i == 12) ? 1'b0 : 1'b1;
         step();
         if (ready && n < 0) n = i;
      end
      pll_locked = 1'b1;
      chk("relock_lat", n, 31);

      // Configuration captured on the very RUN entry edge.
      do_reset();
      div   = {8'd2, 8'd1};
      phase = {8'd1, 8'd0};
      for (int i = 1; i <= 19; i++) begin
         cfg_load = (i == 19);
         step();
      end
      cfg_load = 1'b0;
      chk("entry_ready", 32'(ready), 32'd1);
      for (int i = 0; i < 12; i++) step();

      // Repeated lock losses saturate the counter.
      for (int r = 0; r < 300; r++) begin
         pll_locked = 1'b0;
         step();
         pll_locked = 1'b1;
         step();
         step();
         wait_ready(n, 40);
      end
      chk("sat_lost_cnt", 32'(lost_cnt), 32'd255);
      chk("sat_lock_lost", 32'(lock_lost), 32'd1);
      lost_clr = 1'b1;
      step();
      lost_clr = 1'b0;
      chk("clr_lost_cnt", 32'(lost_cnt), 32'd0);
      chk("clr_lock_lost", 32'(lock_lost), 32'd0);

      // Loss event coinciding with lost_clr.
      for (int r = 0; r < 3; r++) begin
         pll_locked = 1'b0;
         step();
         pll_locked = 1'b1;
         step();
         step();
         wait_ready(n, 40);
      end
      pll_locked = 1'b0;
      step();
      pll_locked = 1'b1;
      step();
      lost_clr = 1'b1;
      step();
      lost_clr = 1'b0;
      chk("clr_evt_cnt", 32'(lost_cnt), 32'd1);
      chk("clr_evt_flag", 32'(lock_lost), 32'd1);
      wait_ready(n, 40);

      // Disabled channel and out-of-range phase never strobe.
      div   = {8'd3, 8'd0};
      phase = {8'd5, 8'd0};
      cfg_load = 1'b1;
      step();
      cfg_load = 1'b0;
      cnt_s = 0;
      for (int i = 0; i < 100; i++) begin
         step();
         if (strobe != '0) cnt_s++;
      end
      chk("quiet_strobes", cnt_s, 0);
      chk("quiet_ready", 32'(ready), 32'd1);

      // Randomized lock glitches, reconfigurations and clears.
      for (int i = 0; i < 2500; i++) begin
         pll_locked = ($urandom_range(0, 299) != 0);
         cfg_load   = ($urandom_range(0, 49) == 0);
         lost_clr   = ($urandom_range(0, 99) == 0);
         for (int k = 0; k < NUM_CH; k++) begin
            div[k*DIV_W +: DIV_W]   = DIV_W'($urandom_range(0, 7));
            phase[k*DIV_W +: DIV_W] = DIV_W'($urandom_range(0, 7));
         end
         step();
      end
      cfg_load   = 1'b0;
      lost_clr   = 1'b0;
      pll_locked = 1'b1;

      // Reset in the middle of RUN with active strobes.
      lost_clr = 1'b1;
      step();
      lost_clr = 1'b0;
      wait_ready(n, 40);
      div   = {8'd1, 8'd1};
      phase = {8'd0, 8'd1};
      cfg_load = 1'b1;
      step();
      cfg_load = 1'b0;
      for (int i = 0; i < 5; i++) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mid_rst_strobe", 32'(strobe), 32'd0);
      chk("mid_rst_ready", 32'(ready), 32'd0);
      chk("mid_rst_lost", 32'(lock_lost), 32'd0);
      chk("mid_rst_cnt", 32'(lost_cnt), 32'd0);
      for (int i = 0; i < 25; i++) step();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/adc_clk_strobe_gen.md
ADC_CLK_STROBE_GEN -- requirements
Module: adc_clk_strobe_gen

Interface
REQ-001 Parameter NUM_CH, default 2, number of independent strobe channels (1..8).
REQ-002 Parameter DIV_W, default 8, width of each channel divide and phase field.
REQ-003 Parameter SETTLE_CYC, default 1024, consecutive locked cycles required before RUN (>=2).
REQ-004 refclk  in  1  sole clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 pll_locked  in  1  PLL lock indication, asynchronous to refclk.
REQ-007 div  in  NUM_CH*DIV_W  per-channel divide value; channel k at bits [k*DIV_W +: DIV_W].
REQ-008 phase  in  NUM_CH*DIV_W  per-channel strobe phase, same packing as div.
REQ-009 cfg_load  in  1  single-cycle pulse; captures div and phase.
REQ-010 lost_clr  in  1  clears lock_lost and lost_cnt.
REQ-011 strobe  out  NUM_CH  per-channel single-cycle clock-enable strobe.
REQ-012 ready  out  1  high while in RUN.
REQ-013 lock_lost  out  1  sticky flag: lock dropped while in RUN.
REQ-014 lost_cnt  out  8  saturating count of RUN-to-WAIT_LOCK transitions.

Function
REQ-015 pll_locked synchronised through 2 flops (lk_s); all decisions use lk_s only.
REQ-016 FSM states WAIT_LOCK, SETTLE, RUN.
REQ-017 WAIT_LOCK -> SETTLE when lk_s=1; settle counter loaded with 0.
REQ-018 SETTLE: counter increments each cycle lk_s=1; lk_s=0 -> WAIT_LOCK; counter reaching SETTLE_CYC-1 with lk_s=1 -> RUN next cycle.
REQ-019 RUN: lk_s=0 -> WAIT_LOCK next cycle; set lock_lost; lost_cnt +1, saturating at 255.
REQ-020 lost_clr and lock-loss event in same cycle: event wins (lock_lost=1, lost_cnt = 1 if previously cleared... i.e. cleared then incremented to 1).
REQ-021 ready = (state==RUN), registered.
REQ-022 Shadow registers div_q/phase_q load on cfg_load in any state; reset values div_q=0, phase_q=0.
REQ-023 Channel counter cnt[k] (DIV_W bits) counts 0..div_q[k], wraps to 0; period = div_q[k]+1 cycles.
REQ-024 All channel counters forced to 0 on first RUN cycle and on the cycle after cfg_load; channels therefore phase-aligned.
REQ-025 strobe[k]=1 iff state==RUN and cnt[k]==phase_q[k] and div_q[k]!=0; registered, one cycle after the matching counter value.
REQ-026 div_q[k]=0: channel disabled, strobe[k] constant 0.
REQ-027 phase_q[k] > div_q[k]: strobe[k] never asserts; no error flag.
REQ-028 Outside RUN: counters held at 0, strobe=0.
REQ-029 cfg_load in same cycle as RUN entry: new values used, counters 0, no extra strobe.
REQ-030 Lock loss mid-period: strobe deasserts the next cycle; no partial strobe after RUN exit.

Reset
REQ-031 rst forces state=WAIT_LOCK, settle counter 0, sync flops 0, all counters 0.
REQ-032 Output reset values: strobe=0, ready=0, lock_lost=0, lost_cnt=0.
REQ-033 rst has priority over cfg_load, lost_clr and all FSM transitions; rst mid-RUN does not increment lost_cnt.

Structure
REQ-034 Package adc_clk_pkg holds the FSM state enum and default NUM_CH/DIV_W/SETTLE_CYC constants.
REQ-035 One sub-module clk_strobe_ch: one channel's counter, compare and strobe register; instantiated NUM_CH times by generate.
REQ-036 Settle counter width = $clog2(SETTLE_CYC).

Verification (NUM_CH=2, DIV_W=8, SETTLE_CYC=16)
REQ-037 rst released, pll_locked=1 held -> ready rises after 2 sync + 16 settle + 1 cycles (within 1 cycle tolerance of 19); strobe 0 before.
REQ-038 div={3,4}, phase={0,2}, cfg_load in RUN -> ch0 strobe every 4 cycles, ch1 every 5 cycles, ch1 offset 2 from first alignment point.
REQ-039 pll_locked drops for 1 synced cycle at settle count 10 -> back to WAIT_LOCK, count restarts, ready delayed accordingly.
REQ-040 pll_locked drops in RUN 300 times -> lock_lost=1, lost_cnt=255 saturated; lost_clr -> both 0.
REQ-041 div=0 on ch0, phase=5>div=3 on ch1 -> both strobes stay 0 for 100 cycles in RUN.
REQ-042 rst asserted mid-RUN with strobes active -> next cycle all outputs at reset values, lost_cnt unchanged 0.
